// File: rtl/ex_unit.sv
// Execute stage: single-cycle ALU ops plus 16-step iterative MUL/DIV,
// with a registered valid/ready result slot toward EX/MEM.
module ex_unit #(
    parameter int S = 15,
    parameter int C = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         InValid,
    output logic         InReady,
    input  logic [S:0]   InData1,
    input  logic [S:0]   InData2,
    input  logic [S:0]   InData15,
    input  logic [C:0]   InCtrl,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [S:0]   OutResult,
    output logic [S:0]   OutData15,
    output logic [C:0]   OutCtrl,
    output logic         OutDivZero
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [C:0] OP_ADD = 4'b0000;
    localparam logic [C:0] OP_SUB = 4'b0001;
    localparam logic [C:0] OP_AND = 4'b0010;
    localparam logic [C:0] OP_OR  = 4'b0011;
    localparam logic [C:0] OP_MUL = 4'b0100;
    localparam logic [C:0] OP_DIV = 4'b0101;
    localparam logic [C:0] OP_MOV = 4'b0110;
    localparam logic [C:0] OP_SLL = 4'b0111;
    localparam logic [C:0] OP_SRL = 4'b1000;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [S:0] m_q, m_d;
    logic [S:0] hi_q, hi_d;
    logic [S:0] lo_q, lo_d;
    logic [C:0] op_q, op_d;
    logic       dz_q, dz_d;
    logic       ov_q, ov_d;
    logic [S:0] res_q, res_d;
    logic [S:0] d15_q, d15_d;
    logic [C:0] octrl_q, octrl_d;
    logic       odz_q, odz_d;

    logic         slot_free;
    logic         accept;
    logic         is_md;
    logic [S:0]   alu_res;
    logic [S+1:0] mul_sum;
    logic [S+1:0] div_r;
    logic [S:0]   div_diff;
    logic         div_ge;

    always_comb begin
        unique case (InCtrl)
            OP_ADD:  alu_res = InData1 + InData2;
            OP_SUB:  alu_res = InData1 - InData2;
            OP_AND:  alu_res = InData1 & InData2;
            OP_OR:   alu_res = InData1 | InData2;
            OP_MOV:  alu_res = InData2;
            OP_SLL:  alu_res = InData1 << InData2[3:0];
            OP_SRL:  alu_res = InData1 >> InData2[3:0];
            default: alu_res = InData1;
        endcase
    end

    // hi_q:lo_q is the product register for MUL and remainder:quotient for DIV
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_r    = {hi_q, lo_q[S]};
        div_ge   = div_r >= {1'b0, m_q};
        div_diff = div_r[S:0] - m_q;
    end

    always_comb begin
        slot_free = !ov_q || OutReady;
        InReady   = (state_q == IDLE) && slot_free;
        accept    = InValid && InReady;
        is_md     = (InCtrl == OP_MUL) || (InCtrl == OP_DIV);

        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        dz_d    = dz_q;
        ov_d    = ov_q && !OutReady;
        res_d   = res_q;
        d15_d   = d15_q;
        octrl_d = octrl_q;
        odz_d   = odz_q;

        unique case (state_q)
            IDLE: begin
                if (accept && is_md) begin
                    m_d     = (InCtrl == OP_MUL) ? InData1 : InData2;
                    lo_d    = (InCtrl == OP_MUL) ? InData2 : InData1;
                    hi_d    = '0;
                    cnt_d   = '0;
                    op_d    = InCtrl;
                    dz_d    = (InCtrl == OP_DIV) && (InData2 == '0);
                    state_d = BUSY;
                end else if (accept) begin
                    res_d   = alu_res;
                    d15_d   = InData15;
                    octrl_d = InCtrl;
                    odz_d   = 1'b0;
                    ov_d    = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q < 5'd16) begin
                    cnt_d = cnt_q + 5'd1;
                    if (op_q == OP_MUL) begin
                        hi_d = mul_sum[S+1:1];
                        lo_d = {mul_sum[0], lo_q[S:1]};
                    end else begin
                        hi_d = div_ge ? div_diff : div_r[S:0];
                        lo_d = {lo_q[S-1:0], div_ge};
                    end
                end else if (slot_free) begin
                    res_d   = lo_q;
                    d15_d   = hi_q;
                    octrl_d = op_q;
                    odz_d   = dz_q;
                    ov_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            res_q   <= '0;
            d15_q   <= '0;
            octrl_q <= '0;
            odz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            res_q   <= res_d;
            d15_q   <= d15_d;
            octrl_q <= octrl_d;
            odz_q   <= odz_d;
        end
    end

    assign OutValid   = ov_q;
    assign OutResult  = res_q;
    assign OutData15  = d15_q;
    assign OutCtrl    = octrl_q;
    assign OutDivZero = odz_q;

endmodule

// File: tb/tb_ex_unit.sv
// Scoreboard bench for ex_unit: expected results queued at accept,
// compared when the result slot is consumed.
module tb_ex_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [15:0] InData1;
    logic [15:0] InData2;
    logic [15:0] InData15;
    logic [3:0]  InCtrl;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] OutResult;
    logic [15:0] OutData15;
    logic [3:0]  OutCtrl;
    logic        OutDivZero;

    typedef struct {
        logic [15:0] res;
        logic [15:0] d15;
        logic [3:0]  ctrl;
        logic        dz;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    ex_unit dut (
        .clk       (clk),
        .rst       (rst),
        .InValid   (InValid),
        .InReady   (InReady),
        .InData1   (InData1),
        .InData2   (InData2),
        .InData15  (InData15),
        .InCtrl    (InCtrl),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutResult (OutResult),
        .OutData15 (OutData15),
        .OutCtrl   (OutCtrl),
        .OutDivZero(OutDivZero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [15:0] d);
        exp_t e;
        logic [31:0] p;
        logic [3:0]  sh;
        sh     = b[3:0];
        e.d15  = d;
        e.ctrl = op;
        e.dz   = 1'b0;
        case (op)
            4'd0: e.res = a + b;
            4'd1: e.res = a - b;
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: begin
                p     = {16'h0, a} * {16'h0, b};
                e.res = p[15:0];
                e.d15 = p[31:16];
            end
            4'd5: begin
                if (b == 16'h0) begin
                    e.res = 16'hFFFF;
                    e.d15 = a;
                    e.dz  = 1'b1;
                end else begin
                    e.res = a / b;
                    e.d15 = a % b;
                end
            end
            4'd6: e.res = b;
            4'd7: e.res = a << sh;
            4'd8: e.res = a >> sh;
            default: e.res = a;
        endcase
        return e;
    endfunction

    // Result is consumed at the next rising edge when valid and ready
    always @(negedge clk) begin
        if (!rst && OutValid && OutReady) begin
            if (expq.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("result", {16'h0, OutResult}, {16'h0, e.res});
                check("data15", {16'h0, OutData15}, {16'h0, e.d15});
                check("ctrl", {28'h0, OutCtrl}, {28'h0, e.ctrl});
                check("divzero", {31'h0, OutDivZero}, {31'h0, e.dz});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] d);
        int n;
        InValid  = 1'b1;
        InCtrl   = op;
        InData1  = a;
        InData2  = b;
        InData15 = d;
        n = 0;
        @(negedge clk);
        while (!InReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!InReady) begin
            check("accept_timeout", 32'd0, 32'd1);
            InValid = 1'b0;
            return;
        end
        @(posedge clk);
        expq.push_back(model(op, a, b, d));
        acc_cyc = cyc;
        #1;
        InValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", expq.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {31'h0, OutValid}, 32'd0);
        check({tag, "_ready"}, {31'h0, InReady}, 32'd1);
        check({tag, "_res"}, {16'h0, OutResult}, 32'd0);
        check({tag, "_d15"}, {16'h0, OutData15}, 32'd0);
        check({tag, "_ctrl"}, {28'h0, OutCtrl}, 32'd0);
        check({tag, "_dz"}, {31'h0, OutDivZero}, 32'd0);
    endtask

    initial begin
        int n;
        int acc[4];
        logic [15:0] held;
        rst      = 1'b1;
        InValid  = 1'b0;
        InData1  = '0;
        InData2  = '0;
        InData15 = '0;
        InCtrl   = '0;
        OutReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        @(posedge clk);
        #1;
        OutReady = 1'b1;
        send(4'd0, 16'h7FFF, 16'h0001, 16'h1234);
        check("add_latency", {31'h0, OutValid}, 32'd1);
        send(4'd1, 16'h0000, 16'h0001, 16'h0001);
        send(4'd7, 16'h0001, 16'h0013, 16'h0002);
        send(4'd2, 16'hF0F0, 16'h3C3C, 16'h0003);
        send(4'd3, 16'hF0F0, 16'h0F0F, 16'h0004);
        send(4'd6, 16'hAAAA, 16'h5555, 16'h0005);
        send(4'd8, 16'h8000, 16'h00F4, 16'h0006);
        send(4'd10, 16'hBEEF, 16'h1111, 16'h0007);
        drain();

        send(4'd4, 16'hFFFF, 16'hFFFF, 16'hDEAD);
        n = 0;
        while (!InReady && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mul_busy_cycles", n, 17);
        check("mul_valid", {31'h0, OutValid}, 32'd1);
        drain();

        send(4'd5, 16'h0064, 16'h0007, 16'h9999);
        drain();
        send(4'd5, 16'h1234, 16'h0000, 16'h8888);
        drain();
        send(4'd4, 16'h1234, 16'h5678, 16'h0000);
        send(4'd5, 16'hFFFF, 16'h0001, 16'h0000);
        drain();

        @(posedge clk);
        #1;
        OutReady = 1'b0;
        send(4'd0, 16'h0001, 16'h0002, 16'h0042);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", {31'h0, InReady}, 32'd0);
            check("bp_valid", {31'h0, OutValid}, 32'd1);
            check("bp_res", {16'h0, OutResult}, 32'h0003);
        end
        @(posedge clk);
        #1;
        OutReady = 1'b1;
        drain();

        @(posedge clk);
        #1;
        OutReady = 1'b0;
        send(4'd4, 16'h00FF, 16'h0101, 16'h0000);
        repeat (16) @(posedge clk);
        #1;
        check("mul_bp_early", {31'h0, OutValid}, 32'd0);
        @(posedge clk);
        #1;
        check("mul_bp_load", {31'h0, OutValid}, 32'd1);
        held = OutResult;
        check("mul_bp_lo", {16'h0, held}, 32'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("mul_bp_hold", {16'h0, OutResult}, {16'h0, held});
        check("mul_bp_hold_ready", {31'h0, InReady}, 32'd0);
        OutReady = 1'b1;
        drain();

        for (int i = 0; i < 4; i++) begin
            send(4'd0, 16'(i * 16'h0100), 16'(i + 1), 16'(i));
            acc[i] = acc_cyc;
        end
        for (int i = 1; i < 4; i++)
            check("stream_gap", acc[i] - acc[i-1], 1);
        drain();

        send(4'd4, 16'h1234, 16'h4321, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        expq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("mid_reset");
        send(4'd0, 16'h0010, 16'h0020, 16'h0077);
        drain();

        do_reset();
        check_reset_state("final_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_unit.md
# ex_unit

Execute-stage consumer of the ID/EX pipeline register in the 16-bit datapath. Accepts one decoded operation per handshake (operand 1, operand 2, the R15 operand, 4-bit control) and computes single-cycle ALU results or iterative 16-cycle multiply/divide results. Results go to the EX/MEM register through a registered valid/ready output. Upstream stalls while a multi-cycle op runs or the output slot is blocked.

## Interface
- S, 15: data MSB (data width S+1 = 16).
- C, 3: control MSB (control width C+1 = 4).

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- InValid  in  1  ID/EX holds a valid operation.
- InReady  out  1  unit accepts the operation this cycle (combinational).
- InData1  in  S+1  operand A.
- InData2  in  S+1  operand B.
- InData15  in  S+1  R15 operand, passed through for non-MUL/DIV ops.
- InCtrl  in  C+1  operation code.
- OutValid  out  1  result register holds a valid result.
- OutReady  in  1  EX/MEM consumes the result this cycle.
- OutResult  out  S+1  primary result.
- OutData15  out  S+1  R15 result: MUL high word, DIV remainder, otherwise InData15.
- OutCtrl  out  C+1  InCtrl of the op that produced the result.
- OutDivZero  out  1  result came from DIV with InData2 == 0.

## Operation
- Opcodes:
  - 0000: ADD, A+B mod 2^16.
  - 0001: SUB, A-B mod 2^16.
  - 0010: AND.
  - 0011: OR.
  - 0100: MUL, unsigned 16x16 -> 32. Low word to OutResult, high word to OutData15.
  - 0101: DIV, unsigned. Quotient to OutResult, remainder to OutData15.
  - 0110: MOV, result = B.
  - 0111: SLL, A << B[3:0].
  - 1000: SRL, logical A >> B[3:0].
  - 1001-1111: pass, result = A.
- Accept occurs when InValid && InReady.
- Output slot free = !OutValid || OutReady.
- FSM states: IDLE, BUSY.
  - IDLE:
    - InReady = slot free.
    - On accept of a single-cycle op: result, InData15, InCtrl and OutDivZero=0 load into the output registers; OutValid=1; stay in IDLE.
    - On accept of MUL/DIV: operands and ctrl latch; iteration counter clears to 0; go to BUSY. OutValid falls if OutReady was high, else holds.
  - BUSY:
    - InReady = 0.
    - One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle while counter < 16.
    - When counter == 16 and slot free: load result, OutValid=1, return to IDLE.
    - Counter saturates at 16 while the slot is blocked; the result is held.
- Output handshake: when OutValid && OutReady && no new load, OutValid clears. Output data is stable while OutValid && !OutReady.
- DIV by zero: OutResult = 0xFFFF, OutData15 = A, OutDivZero = 1. The op still takes the full 16 iterations.
- Inputs are ignored when InReady is low. InData* may change freely after accept.

## Timing
- Reset (rst=1 at an edge): state IDLE, counter 0, OutValid 0, OutResult/OutData15 0x0000, OutCtrl 0, OutDivZero 0.
  - Reset applies in any state. An in-flight MUL/DIV is discarded and a pending result is dropped.
  - InReady = 1 in the first cycle after reset.
- Single-cycle op accepted at edge N: OutValid high after edge N. Throughput is 1 per cycle when OutReady stays high.
- MUL/DIV accepted at edge N:
  - BUSY after N; steps at edges N+1..N+16.
  - Result loads at edge N+17 if the slot is free. OutValid is high after N+17.
  - Next accept is possible at edge N+18 at the earliest.
- Back-to-back: a result may be consumed and a new single-cycle result loaded at the same edge; OutValid stays 1.
- InReady is combinational from state, OutValid and OutReady only. There is no path from InValid.

## Test plan
- Reset then ADD A=0x7FFF, B=0x0001, InData15=0x1234, OutReady=1 -> next cycle OutValid=1, OutResult=0x8000, OutData15=0x1234, OutCtrl=0000.
- SUB A=0x0000, B=0x0001 -> 0xFFFF. SLL A=0x0001, B=0x0013 -> 0x0008 (only B[3:0] used).
- MUL A=0xFFFF, B=0xFFFF accepted at edge N -> InReady low for 17 cycles; after edge N+17, OutResult=0x0001, OutData15=0xFFFE.
- DIV A=0x0064, B=0x0007 -> OutResult=0x000E, OutData15=0x0002, OutDivZero=0. DIV A=0x1234, B=0 -> 0xFFFF, 0x1234, OutDivZero=1.
- Backpressure:
  - Hold OutReady=0 with a result pending -> InReady=0, outputs stable.
  - MUL finishing while blocked -> result loads on the first edge with OutReady=1.
  - A stream of 4 ADDs with OutReady=1 -> 4 results on 4 consecutive cycles.
- Assert rst during MUL BUSY cycle 5 -> after the reset edge OutValid=0, InReady=1, outputs 0. A following ADD completes normally.
